// File: rtl/alu_rs_param_if.sv
// Dispatch, CDB and result bundle for the ALU reservation station.
// master = dispatch/CDB side, slave = reservation station.
interface alu_rs_param_if #(
    parameter int DEPTH   = 16,
    parameter int TAG_W   = 4,
    parameter int XLEN    = 32,
    parameter int OP_W    = 6,
    parameter int NUM_CDB = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [OP_W-1:0]          in_op;
    logic [TAG_W-1:0]         in_tag;
    logic                     in_use_imm;
    logic                     in_rdy1;
    logic [XLEN-1:0]          in_v1;
    logic                     in_rdy2;
    logic [XLEN-1:0]          in_v2;
    logic [XLEN-1:0]          in_imm;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0]  cdb_val;
    logic                     out_valid;
    logic [TAG_W-1:0]         out_tag;
    logic [XLEN-1:0]          out_val;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_op, in_tag, in_use_imm,
        output in_rdy1, in_v1, in_rdy2, in_v2, in_imm,
        output cdb_valid, cdb_tag, cdb_val,
        input  in_ready, out_valid, out_tag, out_val, count
    );

    modport slave (
        input  in_valid, in_op, in_tag, in_use_imm,
        input  in_rdy1, in_v1, in_rdy2, in_v2, in_imm,
        input  cdb_valid, cdb_tag, cdb_val,
        output in_ready, out_valid, out_tag, out_val, count
    );
endinterface

// File: rtl/alu_rs_param.sv
// Parametrised ALU reservation station with multi-channel CDB wakeup.
// Define RS_OLDEST_FIRST_EN to select the oldest ready entry via an age matrix.
module alu_rs_param #(
    parameter int DEPTH   = 16,
    parameter int TAG_W   = 4,
    parameter int XLEN    = 32,
    parameter int OP_W    = 6,
    parameter int NUM_CDB = 2
) (
    input logic clk,
    input logic rst,
    input logic rdy,
    input logic flush,
    alu_rs_param_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int SW = $clog2(XLEN);

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_XORI  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(6);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SLL   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(11);
    localparam logic [OP_W-1:0] OP_SRL   = OP_W'(12);
    localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(13);
    localparam logic [OP_W-1:0] OP_SRA   = OP_W'(14);
    localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(15);
    localparam logic [OP_W-1:0] OP_SLT   = OP_W'(16);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(18);
    localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(19);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(20);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(21);
    localparam logic [OP_W-1:0] OP_BLT   = OP_W'(22);
    localparam logic [OP_W-1:0] OP_BGE   = OP_W'(23);
    localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(24);
    localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(25);
    localparam logic [OP_W-1:0] OP_JALR  = OP_W'(26);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] r1;
    logic [DEPTH-1:0] r2;
    logic [OP_W-1:0]  op_q  [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [XLEN-1:0]  v1_q  [DEPTH];
    logic [XLEN-1:0]  v2_q  [DEPTH];
    logic [CW-1:0]    cnt;

    logic             out_valid_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [XLEN-1:0]  out_val_q;

    logic [NUM_CDB-1:0] cv;
    logic [TAG_W-1:0]   ct [NUM_CDB];
    logic [XLEN-1:0]    cd [NUM_CDB];

    logic             d1_hit;
    logic             d2_hit;
    logic [XLEN-1:0]  d1_val;
    logic [XLEN-1:0]  d2_val;
    logic [DEPTH-1:0] h1;
    logic [DEPTH-1:0] h2;
    logic [XLEN-1:0]  n1 [DEPTH];
    logic [XLEN-1:0]  n2 [DEPTH];

    logic             full;
    logic             acc;
    logic             issue;
    logic [DEPTH-1:0] ready_vec;
    logic [IW-1:0]    free_idx;
    logic [IW-1:0]    sel_idx;

    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [OP_W-1:0]  sop;
    logic [SW-1:0]    sh;
    logic             lt_s;
    logic             lt_u;
    logic             eq;
    logic [XLEN-1:0]  alu_res;

    always_comb begin
        cv = bus.cdb_valid;
        for (int c = 0; c < NUM_CDB; c++) begin
            ct[c] = bus.cdb_tag[c*TAG_W +: TAG_W];
            cd[c] = bus.cdb_val[c*XLEN +: XLEN];
        end
    end

    // Descending scan so the lowest matching channel wins.
    always_comb begin
        d1_hit = 1'b0;
        d2_hit = 1'b0;
        d1_val = '0;
        d2_val = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (cv[c] && ct[c] == bus.in_v1[TAG_W-1:0]) begin
                d1_hit = 1'b1;
                d1_val = cd[c];
            end
            if (cv[c] && ct[c] == bus.in_v2[TAG_W-1:0]) begin
                d2_hit = 1'b1;
                d2_val = cd[c];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            h1[i] = 1'b0;
            h2[i] = 1'b0;
            n1[i] = v1_q[i];
            n2[i] = v2_q[i];
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
                if (cv[c] && ct[c] == v1_q[i][TAG_W-1:0]) begin
                    h1[i] = 1'b1;
                    n1[i] = cd[c];
                end
                if (cv[c] && ct[c] == v2_q[i][TAG_W-1:0]) begin
                    h2[i] = 1'b1;
                    n2[i] = cd[c];
                end
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IW'(i);
        end
    end

    assign ready_vec = busy & r1 & r2;
    assign full      = (cnt == CW'(DEPTH));
    assign acc       = bus.in_valid && !full && rdy && !flush;
    assign issue     = (|ready_vec) && rdy && !flush;

`ifdef RS_OLDEST_FIRST_EN
    // age[j][i] set means entry j was dispatched before entry i.
    logic [DEPTH-1:0] age [DEPTH];
    logic             older;

    always_comb begin
        sel_idx = '0;
        older   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            older = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ready_vec[j] && age[j][i]) older = 1'b1;
            end
            if (ready_vec[i] && !older) sel_idx = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) age[i] <= '0;
        end else if (acc) begin
            for (int j = 0; j < DEPTH; j++) age[j][free_idx] <= 1'b1;
            age[free_idx] <= '0;
        end
    end
`else
    always_comb begin
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready_vec[i]) sel_idx = IW'(i);
        end
    end
`endif

    always_comb begin
        a    = v1_q[sel_idx];
        b    = v2_q[sel_idx];
        sop  = op_q[sel_idx];
        sh   = b[SW-1:0];
        lt_s = $signed(a) < $signed(b);
        lt_u = a < b;
        eq   = a == b;
        case (sop)
            OP_ADD, OP_ADDI:   alu_res = a + b;
            OP_SUB:            alu_res = a - b;
            OP_XOR, OP_XORI:   alu_res = a ^ b;
            OP_OR, OP_ORI:     alu_res = a | b;
            OP_AND, OP_ANDI:   alu_res = a & b;
            OP_SLL, OP_SLLI:   alu_res = a << sh;
            OP_SRL, OP_SRLI:   alu_res = a >> sh;
            OP_SRA, OP_SRAI:   alu_res = $unsigned($signed(a) >>> sh);
            OP_SLT, OP_SLTI,
            OP_BLT:            alu_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_BGE:            alu_res = {{(XLEN-1){1'b0}}, !lt_s};
            OP_SLTU, OP_SLTIU,
            OP_BLTU:           alu_res = {{(XLEN-1){1'b0}}, lt_u};
            OP_BGEU:           alu_res = {{(XLEN-1){1'b0}}, !lt_u};
            OP_BEQ:            alu_res = {{(XLEN-1){1'b0}}, eq};
            OP_BNE:            alu_res = {{(XLEN-1){1'b0}}, !eq};
            OP_JALR:           alu_res = (a + b) & ~{{(XLEN-1){1'b0}}, 1'b1};
            default:           alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_val_q   <= '0;
        end else if (flush) begin
            busy        <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
        end else if (!rdy) begin
            out_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && !r1[i] && h1[i]) begin
                    r1[i]   <= 1'b1;
                    v1_q[i] <= n1[i];
                end
                if (busy[i] && !r2[i] && h2[i]) begin
                    r2[i]   <= 1'b1;
                    v2_q[i] <= n2[i];
                end
            end
            if (issue) busy[sel_idx] <= 1'b0;
            if (acc) begin
                busy[free_idx]  <= 1'b1;
                op_q[free_idx]  <= bus.in_op;
                tag_q[free_idx] <= bus.in_tag;
                r1[free_idx]    <= bus.in_rdy1 | d1_hit;
                v1_q[free_idx]  <= (!bus.in_rdy1 && d1_hit) ? d1_val : bus.in_v1;
                if (bus.in_use_imm) begin
                    r2[free_idx]   <= 1'b1;
                    v2_q[free_idx] <= bus.in_imm;
                end else begin
                    r2[free_idx]   <= bus.in_rdy2 | d2_hit;
                    v2_q[free_idx] <= (!bus.in_rdy2 && d2_hit) ? d2_val : bus.in_v2;
                end
            end
            cnt         <= cnt + CW'(acc) - CW'(issue);
            out_valid_q <= issue;
            if (issue) begin
                out_tag_q <= tag_q[sel_idx];
                out_val_q <= alu_res;
            end
        end
    end

    assign bus.in_ready  = !full;
    assign bus.count     = cnt;
    assign bus.out_valid = out_valid_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_val   = out_val_q;
endmodule

// File: tb/tb_alu_rs_param.sv
// Scoreboard bench for alu_rs_param: directed plan plus randomized traffic
// checked against a slot-level behavioural model of the reservation station.
module tb_alu_rs_param;
    localparam int DEPTH   = 8;
    localparam int TAG_W   = 4;
    localparam int XLEN    = 32;
    localparam int OP_W    = 6;
    localparam int NUM_CDB = 2;

    localparam int ADD = 1, ADDI = 2, SUB = 3, XOR_ = 4, XORI = 5;
    localparam int OR_ = 6, ORI = 7, AND_ = 8, ANDI = 9;
    localparam int SLL = 10, SLLI = 11, SRL = 12, SRLI = 13;
    localparam int SRA = 14, SRAI = 15, SLT = 16, SLTI = 17;
    localparam int SLTU = 18, SLTIU = 19, BEQ = 20, BNE = 21;
    localparam int BLT = 22, BGE = 23, BLTU = 24, BGEU = 25, JALR = 26;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic flush;

    always #5 clk = ~clk;

    alu_rs_param_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN),
                      .OP_W(OP_W), .NUM_CDB(NUM_CDB)) bus ();

    alu_rs_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN),
                   .OP_W(OP_W), .NUM_CDB(NUM_CDB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .bus(bus)
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  val;
        int               due;
    } exp_t;

    exp_t sbq[$];
    logic [TAG_W-1:0] seen[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    bit          m_busy [DEPTH];
    bit          m_r1   [DEPTH];
    bit          m_r2   [DEPTH];
    logic [31:0] m_v1   [DEPTH];
    logic [31:0] m_v2   [DEPTH];
    int          m_op   [DEPTH];
    logic [3:0]  m_tag  [DEPTH];
    longint      m_seq  [DEPTH];
    int          m_count = 0;
    longint      seq_ctr = 0;

    int ops[28] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14,
                    15, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 0, 63};

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] x,
                                            input logic [31:0] y);
        int s;
        logic signed [31:0] sx;
        s  = int'(y[4:0]);
        sx = x;
        case (op)
            ADD, ADDI:         return x + y;
            SUB:               return x - y;
            XOR_, XORI:        return x ^ y;
            OR_, ORI:          return x | y;
            AND_, ANDI:        return x & y;
            SLL, SLLI:         return x << s;
            SRL, SRLI:         return x >> s;
            SRA, SRAI:         return sx >>> s;
            SLT, SLTI, BLT:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            BGE:               return ($signed(x) >= $signed(y)) ? 32'd1 : 32'd0;
            SLTU, SLTIU, BLTU: return (x < y) ? 32'd1 : 32'd0;
            BGEU:              return (x >= y) ? 32'd1 : 32'd0;
            BEQ:               return (x == y) ? 32'd1 : 32'd0;
            BNE:               return (x != y) ? 32'd1 : 32'd0;
            JALR:              return (x + y) & 32'hFFFF_FFFE;
            default:           return 32'd0;
        endcase
    endfunction

    function automatic bit snoop(input logic [3:0] t, output logic [31:0] v);
        v = '0;
        for (int c = 0; c < NUM_CDB; c++) begin
            if (bus.cdb_valid[c] && bus.cdb_tag[c*TAG_W +: TAG_W] == t) begin
                v = bus.cdb_val[c*XLEN +: XLEN];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    // Advance the model across the coming clock edge using the driven inputs.
    task automatic model_step();
        int pick;
        int fr;
        bit acc;
        logic [31:0] w;
        if (rst || flush) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_count = 0;
            return;
        end
        if (!rdy) return;
        pick = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_busy[i] && m_r1[i] && m_r2[i]) begin
`ifdef RS_OLDEST_FIRST_EN
                if (pick < 0 || m_seq[i] < m_seq[pick]) pick = i;
`else
                if (pick < 0) pick = i;
`endif
            end
        end
        fr = -1;
        for (int i = 0; i < DEPTH; i++) if (!m_busy[i] && fr < 0) fr = i;
        acc = bus.in_valid && (m_count < DEPTH);
        if (pick >= 0) begin
            sbq.push_back('{m_tag[pick],
                            ref_alu(m_op[pick], m_v1[pick], m_v2[pick]),
                            cyc_n + 1});
            m_busy[pick] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (m_busy[i] && !m_r1[i] && snoop(m_v1[i][3:0], w)) begin
                m_r1[i] = 1'b1;
                m_v1[i] = w;
            end
            if (m_busy[i] && !m_r2[i] && snoop(m_v2[i][3:0], w)) begin
                m_r2[i] = 1'b1;
                m_v2[i] = w;
            end
        end
        if (acc) begin
            m_busy[fr] = 1'b1;
            m_op[fr]   = int'(bus.in_op);
            m_tag[fr]  = bus.in_tag;
            m_seq[fr]  = seq_ctr++;
            m_r1[fr]   = bus.in_rdy1;
            m_v1[fr]   = bus.in_v1;
            if (!bus.in_rdy1 && snoop(bus.in_v1[3:0], w)) begin
                m_r1[fr] = 1'b1;
                m_v1[fr] = w;
            end
            if (bus.in_use_imm) begin
                m_r2[fr] = 1'b1;
                m_v2[fr] = bus.in_imm;
            end else begin
                m_r2[fr] = bus.in_rdy2;
                m_v2[fr] = bus.in_v2;
                if (!bus.in_rdy2 && snoop(bus.in_v2[3:0], w)) begin
                    m_r2[fr] = 1'b1;
                    m_v2[fr] = w;
                end
            end
        end
        m_count = m_count + (acc ? 1 : 0) - (pick >= 0 ? 1 : 0);
    endtask

    always @(posedge clk) begin : mon
        exp_t e;
        cyc_n++;
        #1;
        chk("count", 64'(bus.count), 64'(m_count));
        chk("in_ready", 64'(bus.in_ready), 64'(m_count != DEPTH));
        if (bus.out_valid) begin
            seen.push_back(bus.out_tag);
            if (sbq.size() == 0) begin
                chk("out_valid_unexpected", 64'(bus.out_valid), 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
                chk("out_val", 64'(bus.out_val), 64'(e.val));
                chk("out_cycle", 64'(cyc_n), 64'(e.due));
            end
        end else if (sbq.size() > 0 && sbq[0].due <= cyc_n) begin
            e = sbq.pop_front();
            chk("out_valid_missing", 64'(bus.out_valid), 64'd1);
        end
    end

    task automatic tick();
        model_step();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.cdb_valid = '0;
    endtask

    task automatic disp(input int op, input int tag, input bit use_imm,
                        input bit r1, input logic [31:0] v1,
                        input bit r2, input logic [31:0] v2,
                        input logic [31:0] imm);
        bus.in_valid   = 1'b1;
        bus.in_op      = OP_W'(op);
        bus.in_tag     = TAG_W'(tag);
        bus.in_use_imm = use_imm;
        bus.in_rdy1    = r1;
        bus.in_v1      = v1;
        bus.in_rdy2    = r2;
        bus.in_v2      = v2;
        bus.in_imm     = imm;
    endtask

    task automatic cdb(input int ch, input int tag, input logic [31:0] val);
        bus.cdb_valid[ch]               = 1'b1;
        bus.cdb_tag[ch*TAG_W +: TAG_W]  = TAG_W'(tag);
        bus.cdb_val[ch*XLEN +: XLEN]    = val;
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        flush = 1'b0;
        bus.cdb_valid = '0;
        bus.cdb_tag = '0;
        bus.cdb_val = '0;
        disp(0, 0, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_out_val", 64'(bus.out_val), 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        disp(ADDI, 3, 1, 1, 5, 0, 0, 7);
        tick();
        chk("addi_not_early", 64'(bus.out_valid), 64'd0);
        tick();
        chk("addi_valid", 64'(bus.out_valid), 64'd1);
        chk("addi_tag", 64'(bus.out_tag), 64'd3);
        chk("addi_val", 64'(bus.out_val), 64'd12);
        chk("addi_count", 64'(bus.count), 64'd0);
        tick();
        chk("addi_one_cycle", 64'(bus.out_valid), 64'd0);

        disp(SUB, 2, 0, 0, 9, 1, 4, 0);
        tick();
        tick();
        tick();
        chk("sub_waiting", 64'(bus.out_valid), 64'd0);
        cdb(1, 9, 10);
        tick();
        tick();
        chk("sub_valid", 64'(bus.out_valid), 64'd1);
        chk("sub_val", 64'(bus.out_val), 64'd6);
        tick();

        disp(SRAI, 1, 1, 0, 5, 0, 0, 4);
        cdb(0, 5, 32'hFFFF_FFFF);
        tick();
        tick();
        chk("srai_val", 64'(bus.out_val), 64'hFFFF_FFFF);
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            disp(ADD, i, 0, 0, 8 + i, 1, 1, 0);
            tick();
        end
        chk("full_count", 64'(bus.count), 64'(DEPTH));
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        disp(ADD, 15, 0, 1, 1, 1, 1, 0);
        tick();
        cdb(0, 8, 100);
        tick();
        chk("full_still", 64'(bus.in_ready), 64'd0);
        disp(ADD, 14, 0, 1, 2, 1, 2, 0);
        tick();
        chk("full_issue_tag", 64'(bus.out_tag), 64'd0);
        chk("full_issue_val", 64'(bus.out_val), 64'd101);
        chk("full_ignored", 64'(bus.count), 64'(DEPTH - 1));
        chk("full_freed", 64'(bus.in_ready), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        for (int i = 0; i < 3; i++) begin
            disp(XOR_, i + 1, 0, 0, 4 + i, 1, 3, 0);
            tick();
        end
        flush = 1'b1;
        disp(ADD, 9, 0, 1, 1, 1, 1, 0);
        tick();
        flush = 1'b0;
        chk("flush_count", 64'(bus.count), 64'd0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        cdb(0, 4, 1);
        cdb(1, 5, 2);
        tick();
        cdb(0, 6, 3);
        tick();
        tick();
        chk("flush_no_out", 64'(bus.out_valid), 64'd0);

        disp(ADD, 7, 0, 0, 1, 1, 1, 0);
        tick();
        disp(ADD, 10, 0, 0, 2, 1, 1, 0);
        tick();
        cdb(0, 1, 50);
        tick();
        tick();
        disp(ADD, 11, 0, 0, 2, 1, 1, 0);
        tick();
        cdb(0, 2, 60);
        tick();
        tick();
        tick();
        tick();
`ifdef RS_OLDEST_FIRST_EN
        chk("age_first", 64'(seen[seen.size() - 2]), 64'd10);
        chk("age_second", 64'(seen[seen.size() - 1]), 64'd11);
`else
        chk("age_first", 64'(seen[seen.size() - 2]), 64'd11);
        chk("age_second", 64'(seen[seen.size() - 1]), 64'd10);
`endif

        for (int n = 0; n < 3000; n++) begin
            rdy = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) < 6) begin
                disp(ops[$urandom_range(0, 27)], $urandom_range(0, 15),
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 1) == 1, rv(),
                     $urandom_range(0, 1) == 1, rv(), rv());
            end
            for (int c = 0; c < NUM_CDB; c++) begin
                if ($urandom_range(0, 9) < 4) cdb(c, $urandom_range(0, 15), rv());
            end
            tick();
        end

        rdy = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
